ravan_encryption: RTL and testbench

Iterative 64-bit block encryptor for the RAVAN 512-bit crypto engine, i.e. the transmit-side counterpart of the team's decryption core. It accepts a plaintext block, a 64-bit tweak and a 512-bit key over a valid/ready handshake. It runs ROUNDS×8 key-slice steps at one step per clock and returns a masked ciphertext block over a second valid/ready handshake. Its output feeds the RAVAN decryption path, which undoes the same per-step transform in reverse slice order.

---
 rtl/ravan_encryption.sv | 122 ++++++++++++
 tb/tb_ravan_encryption.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ravan_encryption.sv
// RAVAN 64-bit iterative block encryptor: ROUNDS x 8 key-slice steps, one per clock,
// with a whitening mask drawn from an LFSR that advances once per accepted block.
module ravan_encryption #(
  parameter int          ROUNDS    = 21,
  parameter logic [63:0] MASK_SEED = 64'hffda_1234_daae_a339
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  data_in,
  input  logic [63:0]  real_data,
  input  logic [511:0] key,
  output logic [63:0]  enc_data_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic [1:0]   dbg_state_o
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [63:0]    t_q, t_d;
  logic [63:0]    m_cur_q, m_cur_d;
  logic [63:0]    tw_q, tw_d;
  logic [511:0]   ks_q, ks_d;
  logic [RW-1:0]  r_q, r_d;
  logic [2:0]     s_q, s_d;
  logic [63:0]    mask_q, mask_d;
  logic [63:0]    enc_q, enc_d;

  logic [63:0]    step_val;
  logic           last_step;

  // Both handshakes: a transfer happens on the rising edge where valid and ready
  // are both high; valid never depends on ready, and data is held until transfer.
  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign enc_data_out = enc_q;
  assign dbg_state_o  = state_q;

  assign step_val  = (~(t_q ^ ks_q[{s_q, 6'd0} +: 64])) + tw_q;
  assign last_step = (r_q == R_LAST) && (s_q == 3'd7);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    m_cur_d = m_cur_q;
    tw_d    = tw_q;
    ks_d    = ks_q;
    r_d     = r_q;
    s_d     = s_q;
    mask_d  = mask_q;
    enc_d   = enc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          t_d     = data_in ^ mask_q;
          m_cur_d = mask_q;
          tw_d    = real_data;
          ks_d    = key;
          r_d     = '0;
          s_d     = '0;
          mask_d  = {mask_q[62:0], mask_q[63] ^ mask_q[61]};
        end
      end
      RUN: begin
        t_d = step_val;
        s_d = s_q + 3'd1;
        if (s_q == 3'd7) begin
          r_d = r_q + RW'(1);
        end
        if (last_step) begin
          state_d = DONE;
          r_d     = '0;
          enc_d   = step_val ^ m_cur_q;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      m_cur_q <= '0;
      tw_q    <= '0;
      ks_q    <= '0;
      r_q     <= '0;
      s_q     <= '0;
      mask_q  <= MASK_SEED;
      enc_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      m_cur_q <= m_cur_d;
      tw_q    <= tw_d;
      ks_q    <= ks_d;
      r_q     <= r_d;
      s_q     <= s_d;
      mask_q  <= mask_d;
      enc_q   <= enc_d;
    end
  end

endmodule

// File: tb/tb_ravan_encryption.sv
// Bench for ravan_encryption: transaction-level timing model plus arithmetic
// encrypt/decrypt reference, checked every cycle, with directed and random blocks.
module tb_ravan_encryption;
  localparam int          ROUNDS = 21;
  localparam int          LAT    = 8 * ROUNDS + 1;
  localparam logic [63:0] SEED   = 64'hffda_1234_daae_a339;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [63:0]  data_in, real_data;
  logic [511:0] key;
  logic         in_ready, out_valid, busy;
  logic [63:0]  enc_data_out;
  logic [1:0]   dbg_state;

  ravan_encryption dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .real_data(real_data), .key(key),
    .enc_data_out(enc_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic
  function automatic logic [63:0] mask_at(input int n);
    logic [63:0] m = SEED;
    for (int i = 0; i < n; i++) m = {m[62:0], m[63] ^ m[61]};
    return m;
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [63:0] tw,
                                          input logic [511:0] k, input logic [63:0] m);
    logic [63:0] t = pt ^ m;
    for (int r = 0; r < ROUNDS; r++)
      for (int s = 0; s < 8; s++) t = (~(t ^ k[64*s +: 64])) + tw;
    return t ^ m;
  endfunction

  function automatic logic [63:0] decrypt(input logic [63:0] ct, input logic [63:0] tw,
                                          input logic [511:0] k, input logic [63:0] m);
    logic [63:0] t = ct ^ m;
    for (int r = 0; r < ROUNDS; r++)
      for (int s = 7; s >= 0; s--) t = (~(t - tw)) ^ k[64*s +: 64];
    return t ^ m;
  endfunction

  // Transaction model: tracks whether a block is in flight, when it was
  // accepted, and which ciphertext it must produce.
  int          cyc = 0;
  bit          m_idle = 1'b1;
  int          m_acc = 0;
  int          m_blk = 0;
  logic [63:0] m_ct = '0;
  logic [63:0] exp_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_idle = 1'b1;
      m_blk  = 0;
      exp_q.delete();
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 1'b0;
        m_acc  = cyc;
        m_ct   = encrypt(data_in, real_data, key, mask_at(m_blk));
        exp_q.push_back(m_ct);
        m_blk++;
      end
    end else if ((cyc - m_acc) >= LAT && out_ready) begin
      m_idle = 1'b1;
      void'(exp_q.pop_front());
    end
  end

  bit chk_en = 1'b0;
  int dut_xfer = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_v;
      exp_v = !m_idle && ((cyc - m_acc) >= LAT - 1);
      check("in_ready", 64'(in_ready), 64'(m_idle));
      check("busy", 64'(busy), 64'(!m_idle));
      check("out_valid", 64'(out_valid), 64'(exp_v));
      if (exp_v && exp_q.size() > 0) check("enc_data_out", enc_data_out, exp_q[0]);
      if (out_valid && out_ready && !rst) dut_xfer++;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [63:0] d, input logic [63:0] tw, input logic [511:0] k,
                      output int acc_e);
    int n = 0;
    while (!in_ready && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      n_total++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    data_in   = d;
    real_data = tw;
    key       = k;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    acc_e = cyc;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int acc_e, output logic [63:0] ct, output int lat);
    lat = -1;
    ct  = '0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - acc_e + 1;
        ct  = enc_data_out;
        break;
      end
    end
    if (lat < 0) begin
      n_total++;
      $display("FAIL wait_out_timeout: out_valid got 0 expected 1");
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [511:0] rand_key();
    logic [511:0] k;
    for (int i = 0; i < 16; i++) k[32*i +: 32] = $urandom();
    return k;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] k, k_rt;
    logic [63:0]  d, tw, ct, ct0, ct1, hold;
    int           acc, acc0, acc1, lat, idx, xb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; real_data = '0; key = '0;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset enc_data_out", enc_data_out, 64'd0);
    tick();
    rst = 1'b0;

    // Identity: zero key and tweak make every step a plain inversion
    send(64'h0123_4567_89ab_cdef, 64'h0, '0, acc);
    wait_out(acc, ct, lat);
    check("identity ct", ct, 64'h0123_4567_89ab_cdef);
    check("identity latency", 64'(lat), 64'd169);
    take();

    // Tweak negation: each step is two's-complement negation
    send(64'h5, 64'h1, '0, acc);
    wait_out(acc, ct, lat);
    check("negate ct", ct, 64'h5);
    check("negate latency", 64'(lat), 64'd169);
    take();

    // Round trip, two back-to-back blocks with mask indices 0 and 1
    do_reset();
    for (int i = 0; i < 8; i++) k_rt[64*i +: 64] = 64'h1111_1111_1111_1111 * 64'(i + 1);
    tw = 64'hdead_beef_0000_0001;
    out_ready = 1'b1;
    send(64'h0, tw, k_rt, acc0);
    wait_out(acc0, ct0, lat);
    send(64'hffff_ffff_ffff_ffff, tw, k_rt, acc1);
    wait_out(acc1, ct1, lat);
    out_ready = 1'b0;
    check("rt block period", 64'(acc1 - acc0), 64'd170);
    check("rt ct0 model", ct0, encrypt(64'h0, tw, k_rt, SEED));
    check("rt ct1 model", ct1, encrypt(64'hffff_ffff_ffff_ffff, tw, k_rt, mask_at(1)));
    check("rt decrypt0", decrypt(ct0, tw, k_rt, mask_at(0)), 64'h0);
    check("rt decrypt1", decrypt(ct1, tw, k_rt, mask_at(1)), 64'hffff_ffff_ffff_ffff);
    take();

    // Backpressure: hold out_ready low for 50 cycles
    send(64'($urandom()) << 32 | 64'($urandom()), 64'($urandom()), rand_key(), acc);
    wait_out(acc, hold, lat);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("bp enc stable", enc_data_out, hold);
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp in_ready", 64'(in_ready), 64'd0);
    end
    xb = dut_xfer;
    take();
    @(negedge clk);
    check("bp one transfer", 64'(dut_xfer - xb), 64'd1);
    check("bp in_ready after", 64'(in_ready), 64'd1);
    check("bp out_valid after", 64'(out_valid), 64'd0);

    // Input isolation: inputs churn every cycle while the block runs
    d = {32'($urandom()), 32'($urandom())};
    tw = {32'($urandom()), 32'($urandom())};
    k = rand_key();
    send(d, tw, k, acc);
    idx = m_blk - 1;
    for (int i = 0; i < 160; i++) begin
      data_in   = {32'($urandom()), 32'($urandom())};
      real_data = {32'($urandom()), 32'($urandom())};
      key       = rand_key();
      in_valid  = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    wait_out(acc, ct, lat);
    check("isolation ct", ct, encrypt(d, tw, k, mask_at(idx)));
    take();

    // Reset mid-run at T+80
    send(64'h1234, 64'h77, rand_key(), acc);
    repeat (79) @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    check("midrst busy", 64'(busy), 64'd0);
    d = {32'($urandom()), 32'($urandom())};
    tw = {32'($urandom()), 32'($urandom())};
    k = rand_key();
    send(d, tw, k, acc);
    wait_out(acc, ct, lat);
    check("midrst seed decrypt", decrypt(ct, tw, k, SEED), d);
    take();

    // Random blocks with random consumer behaviour
    for (int b = 0; b < 6; b++) begin
      out_ready = 1'($urandom_range(0, 1));
      send({32'($urandom()), 32'($urandom())}, {32'($urandom()), 32'($urandom())},
           rand_key(), acc);
      wait_out(acc, ct, lat);
      if (!out_ready) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        take();
      end else begin
        out_ready = 1'b0;
        take();
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
